// File: rtl/nios2_mul_share_arbiter.sv
// Round-robin arbiter sharing one 32x32->32 multiplier cell between NUM_REQ requesters.
// One operation in flight; result returned with the winning requester's ID.
module nios2_mul_share_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 1,
    parameter int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [32*NUM_REQ-1:0]   req_src1,
    input  logic [32*NUM_REQ-1:0]   req_src2,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [31:0]             mul_src1,
    output logic [31:0]             mul_src2,
    input  logic [31:0]             mul_result,
    output logic                    rsp_valid,
    output logic [31:0]             rsp_data,
    output logic [ID_W-1:0]         rsp_id,
    input  logic                    rsp_ready,
    output logic                    busy
);

    localparam int unsigned NREQ_U = NUM_REQ;
    localparam int          CNT_W  = (MUL_LATENCY < 1) ? 1 : $clog2(MUL_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    state_e            state_q;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   rr_ptr_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       mul_src1_q;
    logic [31:0]       mul_src2_q;
    logic [31:0]       rsp_data_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic              rsp_valid_q;
    logic              busy_q;

    logic [31:0]       src1_arr [NUM_REQ];
    logic [31:0]       src2_arr [NUM_REQ];
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign src1_arr[g] = req_src1[32*g+31:32*g];
        assign src2_arr[g] = req_src2[32*g+31:32*g];
    end

    // Search rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ; first valid requester wins.
    always_comb begin
        int unsigned idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int unsigned k = 0; k < NREQ_U; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NREQ_U) begin
                idx = idx - NREQ_U;
            end
            if (!grant_found && req_valid[idx[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        if (rsp_id_q == ID_W'(NUM_REQ - 1)) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = rsp_id_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            mul_src1_q  <= '0;
            mul_src2_q  <= '0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        mul_src1_q <= src1_arr[grant_idx];
                        mul_src2_q <= src2_arr[grant_idx];
                        rsp_id_q   <= grant_idx;
                        cnt_q      <= CNT_W'(MUL_LATENCY);
                        state_q    <= BUSY;
                        busy_q     <= 1'b1;
                    end
                end
                BUSY: begin
                    // Operands stay put while the cell pipeline drains.
                    if (cnt_q == '0) begin
                        rsp_data_q  <= mul_result;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rr_ptr_q    <= rr_ptr_d;
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign mul_src1  = mul_src1_q;
    assign mul_src2  = mul_src2_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_valid = rsp_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_nios2_mul_share_arbiter.sv
// Directed bench for nios2_mul_share_arbiter with a one-edge multiplier cell model.
module tb_nios2_mul_share_arbiter;

    logic          clk;
    logic          reset_n;
    logic [3:0]    req_valid;
    logic [127:0]  req_src1;
    logic [127:0]  req_src2;
    logic [3:0]    req_ready;
    logic [31:0]   mul_src1;
    logic [31:0]   mul_src2;
    logic [31:0]   mul_result;
    logic          rsp_valid;
    logic [31:0]   rsp_data;
    logic [1:0]    rsp_id;
    logic          rsp_ready;
    logic          busy;

    int nvec = 0;
    int nmis = 0;

    nios2_mul_share_arbiter #(
        .NUM_REQ     (4),
        .MUL_LATENCY (1),
        .ID_W        (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_src1   (req_src1),
        .req_src2   (req_src2),
        .req_ready  (req_ready),
        .mul_src1   (mul_src1),
        .mul_src2   (mul_src2),
        .mul_result (mul_result),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .rsp_ready  (rsp_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier cell: result valid one edge after operands, shares reset_n.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) mul_result <= '0;
        else          mul_result <= mul_src1 * mul_src2;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int id, input logic [31:0] a, input logic [31:0] b);
        req_src1[32*id +: 32] = a;
        req_src2[32*id +: 32] = b;
    endtask

    // Called at a negedge with the DUT idle and rsp_ready=1; returns at negedge of T+4 (idle again).
    task automatic run_op(input string tag, input logic [3:0] vmask, input int exp_id,
                          input logic [31:0] exp_data);
        req_valid = vmask;
        #1;
        check_eq({tag, "_grant"}, 32'(req_ready), 32'(1) << exp_id);
        @(negedge clk);
        check_eq({tag, "_busy_t1"}, 32'(busy), 32'd1);
        check_eq({tag, "_rv_t1"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, "_rdy_t1"}, 32'(req_ready), 32'd0);
        @(negedge clk);
        check_eq({tag, "_rv_t2"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check_eq({tag, "_rv_t3"}, 32'(rsp_valid), 32'd1);
        check_eq({tag, "_data"}, rsp_data, exp_data);
        check_eq({tag, "_id"}, 32'(rsp_id), 32'(exp_id));
        check_eq({tag, "_rdy_t3"}, 32'(req_ready), 32'd0);
        @(negedge clk);
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_src1  = '0;
        req_src2  = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);

        check_eq("rst_rv", 32'(rsp_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rdy", 32'(req_ready), 32'd0);
        check_eq("rst_data", rsp_data, 32'd0);
        check_eq("rst_src1", mul_src1, 32'd0);
        check_eq("rst_id", 32'(rsp_id), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single requester
        set_src(1, 32'd3, 32'd5);
        run_op("t1", 4'b0010, 1, 32'd15);
        req_valid = '0;

        // Full contention from reset: grants rotate 0,1,2,3,0
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) set_src(i, 32'(i), 32'd2);
        run_op("t2a", 4'b1111, 0, 32'd0);
        run_op("t2b", 4'b1111, 1, 32'd2);
        run_op("t2c", 4'b1111, 2, 32'd4);
        run_op("t2d", 4'b1111, 3, 32'd6);
        run_op("t2e", 4'b1111, 0, 32'd0);
        req_valid = '0;

        // Wrap cases (rr_ptr is 1 here)
        set_src(1, 32'hFFFF_FFFF, 32'd2);
        run_op("t3", 4'b0010, 1, 32'hFFFF_FFFE);
        req_valid = '0;
        set_src(2, 32'h0001_0000, 32'h0001_0000);
        run_op("t4", 4'b0100, 2, 32'h0000_0000);
        req_valid = '0;

        // Response stall with other requesters pending
        set_src(3, 32'h0000_1234, 32'h0000_0010);
        rsp_ready = 1'b0;
        req_valid = 4'b1000;
        #1;
        check_eq("t5_grant", 32'(req_ready), 32'h8);
        @(negedge clk);
        req_valid = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check_eq("t5_rv", 32'(rsp_valid), 32'd1);
            check_eq("t5_data", rsp_data, 32'h0001_2340);
            check_eq("t5_id", 32'(rsp_id), 32'd3);
            check_eq("t5_rdy", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("t5_release", 32'(rsp_valid), 32'd0);

        // Reset while BUSY discards the op
        set_src(0, 32'd5, 32'd5);
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = '0;
        check_eq("t6_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("t6_rv", 32'(rsp_valid), 32'd0);
        check_eq("t6_busy_rst", 32'(busy), 32'd0);
        check_eq("t6_src1", mul_src1, 32'd0);
        check_eq("t6_src2", mul_src2, 32'd0);
        check_eq("t6_data", rsp_data, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("t6_no_rsp", 32'(rsp_valid), 32'd0);
        set_src(2, 32'd7, 32'd6);
        run_op("t6", 4'b0100, 2, 32'd42);
        req_valid = '0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
